fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register feeding the Control decoder.
//  Holds the PC and issues requests over a ready-handshake instruction-memory port.
//  Presents the latched instruction, its opCode and a valid flag to decode.
//  Obeys decode's stall and redirects the PC on Control's branch output,
//  squashing any wrong-path instruction.
// PARAMETERS
//  PC_WIDTH     8   PC / instruction address width; PC wraps modulo 2**PC_WIDTH
//  INSTR_WIDTH  16  instruction width; opCode = instr[INSTR_WIDTH-1 -: 6]
// PORTS
//  clk           in   1            single clock, rising edge
//  resetN        in   1            asynchronous, active-low reset
//  stall         in   1            decode cannot accept; IF/ID must hold
//  branch        in   1            redirect from Control (taken branch)
//  branchTarget  in   PC_WIDTH     new PC when branch=1
//  instrReq      out  1            fetch request to instruction memory
//  instrAddr     out  PC_WIDTH     fetch address (= pc); stable while instrReq=1 and no ready
//  instrReady    in   1            memory returns instrData this cycle
//  instrData     in   INSTR_WIDTH  fetched instruction, valid when instrReady=1
//  ifIdValid     out  1            IF/ID holds a real instruction
//  ifIdInstr     out  INSTR_WIDTH  latched instruction
//  ifIdPc        out  PC_WIDTH     address of ifIdInstr
//  opCode        out  6            ifIdInstr[INSTR_WIDTH-1 -: 6], drives Control.opCode
// BEHAVIOUR
//  Reset (async, resetN=0): pc=0, state=REQ, skid buffer empty;
//   instrReq=0, ifIdValid=0, ifIdInstr=0, ifIdPc=0, opCode=0.
//  instrReq=1 in REQ and DROP when resetN=1; 0 in FULL.
//  Handshake completes on clk edge with instrReq & instrReady.
//  REQ:
//   - ready & !stall & !branch: IF/ID <= {instrData, pc}, valid=1, pc<=pc+1; stay REQ.
//     Back-to-back fetches give one instruction per cycle with zero-wait memory.
//   - ready & stall & !branch: data -> skid buffer, pc<=pc+1, -> FULL.
//     IF/ID is unchanged.
//   - !ready & !branch: hold pc/instrAddr; IF/ID holds if stall, else valid<=0 (bubble).
//  FULL (instrReq=0):
//   - !stall & !branch: IF/ID <= buffer, valid=1, -> REQ.
//  Branch (priority over stall and ready, any state): IF/ID valid<=0 (flush).
//   - REQ with ready, or FULL: drop data/buffer, pc<=branchTarget, -> REQ.
//   - REQ without ready: latch branchTarget, -> DROP. instrReq and instrAddr are kept
//     (request already issued).
//  DROP: on ready discard instrData, pc<=latched target, -> REQ.
//   - Until then IF/ID valid=0.
//   - A second branch in DROP replaces the latched target.
//  pc+1 at all-ones wraps to 0. No combinational path from stall/branch to instrAddr.
//  Reset asserted mid-request drops it. Memory must tolerate a request with no wait for ready.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - adds output bubbleCount [15:0]. Reset 0.
//   - +1 on every clk where resetN=1 and IF/ID valid is 0 after the edge; saturates at 16'hFFFF.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset then zero-wait ROM (instrReady=1), ROM[a]=a*16'h0401
//    -> ifIdPc 0,1,2,3 on consecutive cycles; opCode = ifIdPc[5:0].
//  2 stall=1 for 3 cycles while ready=1
//    -> IF/ID frozen; 1 item in skid buffer; instrReq=0 in FULL; no instruction lost/duplicated.
//  3 branch=1, branchTarget=8'h40 at ifIdPc=5
//    -> next cycle ifIdValid=0; following valid instr has ifIdPc=8'h40.
//  4 instrReady delayed 3 cycles; branch (target 8'h20) in first wait cycle
//    -> instrAddr stable 3 cycles; returned data discarded; next request addr 8'h20.
//  5 pc=8'hFF, zero-wait -> ifIdPc FF then 00.
//  6 resetN low mid-request (async, between edges) -> outputs zero immediately.
//    Release: instrAddr=0, instrReq=1.
//    With FETCH_PERF_CNT_EN, bubbleCount returns to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one-entry skid buffer and branch drop.
// Optional FETCH_PERF_CNT_EN adds a saturating IF/ID bubble counter.
module fetch_stage #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   stall,
  input  logic                   branch,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  output logic                   instrReq,
  output logic [PC_WIDTH-1:0]    instrAddr,
  input  logic                   instrReady,
  input  logic [INSTR_WIDTH-1:0] instrData,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]            bubbleCount,
`endif
  output logic                   ifIdValid,
  output logic [INSTR_WIDTH-1:0] ifIdInstr,
  output logic [PC_WIDTH-1:0]    ifIdPc,
  output logic [5:0]             opCode
);

  typedef enum logic [1:0] {
    S_REQ,
    S_FULL,
    S_DROP
  } state_t;

  state_t                 r_state, w_state;
  logic [PC_WIDTH-1:0]    r_pc, w_pc;
  logic [PC_WIDTH-1:0]    r_tgt, w_tgt;
  logic [INSTR_WIDTH-1:0] r_skid, w_skid;
  logic [PC_WIDTH-1:0]    r_skid_pc, w_skid_pc;
  logic                   r_valid, w_valid;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr;
  logic [PC_WIDTH-1:0]    r_ifpc, w_ifpc;
  logic [PC_WIDTH-1:0]    w_pc_inc;

  assign w_pc_inc  = r_pc + PC_WIDTH'(1);
  assign instrReq  = resetN & (r_state != S_FULL);
  assign instrAddr = r_pc;
  assign ifIdValid = r_valid;
  assign ifIdInstr = r_instr;
  assign ifIdPc    = r_ifpc;
  assign opCode    = r_instr[INSTR_WIDTH-1 -: 6];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_REQ;
      r_pc      <= '0;
      r_tgt     <= '0;
      r_skid    <= '0;
      r_skid_pc <= '0;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_ifpc    <= '0;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_tgt     <= w_tgt;
      r_skid    <= w_skid;
      r_skid_pc <= w_skid_pc;
      r_valid   <= w_valid;
      r_instr   <= w_instr;
      r_ifpc    <= w_ifpc;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_tgt     = r_tgt;
    w_skid    = r_skid;
    w_skid_pc = r_skid_pc;
    w_valid   = r_valid;
    w_instr   = r_instr;
    w_ifpc    = r_ifpc;
    unique case (r_state)
      S_REQ: begin
        if (branch) begin
          w_valid = 1'b0;
          if (instrReady) begin
            w_pc = branchTarget;
          end else begin
            w_tgt   = branchTarget;
            w_state = S_DROP;
          end
        end else if (instrReady) begin
          w_pc = w_pc_inc;
          if (!stall) begin
            w_instr = instrData;
            w_ifpc  = r_pc;
            w_valid = 1'b1;
          end else begin
            w_skid    = instrData;
            w_skid_pc = r_pc;
            w_state   = S_FULL;
          end
        end else if (!stall) begin
          w_valid = 1'b0;
        end
      end
      S_FULL: begin
        if (branch) begin
          w_valid = 1'b0;
          w_pc    = branchTarget;
          w_state = S_REQ;
        end else if (!stall) begin
          w_instr = r_skid;
          w_ifpc  = r_skid_pc;
          w_valid = 1'b1;
          w_state = S_REQ;
        end
      end
      S_DROP: begin
        // The outstanding request must complete before the redirect is issued
        w_valid = 1'b0;
        if (branch) begin
          w_tgt = branchTarget;
        end
        if (instrReady) begin
          w_pc    = branch ? branchTarget : r_tgt;
          w_state = S_REQ;
        end
      end
      default: begin
        w_state = S_REQ;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_bub;

  assign bubbleCount = r_bub;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bub <= '0;
    end else if (!w_valid && (r_bub != 16'hFFFF)) begin
      r_bub <= r_bub + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait ROM, stall/skid, branches,
// delayed ready with drop, PC wrap and async reset.
module tb_fetch_stage;

  logic        clk;
  logic        resetN;
  logic        stall;
  logic        branch;
  logic [7:0]  branchTarget;
  logic        instrReq;
  logic [7:0]  instrAddr;
  logic        instrReady;
  logic [15:0] instrData;
  logic        ifIdValid;
  logic [15:0] ifIdInstr;
  logic [7:0]  ifIdPc;
  logic [5:0]  opCode;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubbleCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(16)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .stall(stall),
    .branch(branch),
    .branchTarget(branchTarget),
    .instrReq(instrReq),
    .instrAddr(instrAddr),
    .instrReady(instrReady),
    .instrData(instrData),
`ifdef FETCH_PERF_CNT_EN
    .bubbleCount(bubbleCount),
`endif
    .ifIdValid(ifIdValid),
    .ifIdInstr(ifIdInstr),
    .ifIdPc(ifIdPc),
    .opCode(opCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [7:0] a);
    logic [15:0] t;
    t = {8'h00, a} * 16'h0401;
    return t;
  endfunction

  assign instrData = rom(instrAddr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [7:0] pc);
    chk({tag, ".valid"}, 32'(ifIdValid), 32'd1);
    chk({tag, ".pc"}, 32'(ifIdPc), 32'(pc));
    chk({tag, ".instr"}, 32'(ifIdInstr), 32'(rom(pc)));
    chk({tag, ".op"}, 32'(opCode), 32'(pc[5:0]));
  endtask

  initial begin
    resetN       = 1'b0;
    stall        = 1'b0;
    branch       = 1'b0;
    branchTarget = 8'h00;
    instrReady   = 1'b1;
    #12;
    chk("rst.req", 32'(instrReq), 32'd0);
    chk("rst.valid", 32'(ifIdValid), 32'd0);
    chk("rst.pc", 32'(ifIdPc), 32'd0);
    chk("rst.instr", 32'(ifIdInstr), 32'd0);
    chk("rst.op", 32'(opCode), 32'd0);
    chk("rst.addr", 32'(instrAddr), 32'd0);
    step();
    resetN = 1'b1;
    #1;
    chk("rel.req", 32'(instrReq), 32'd1);

    // zero-wait stream
    for (int i = 0; i < 4; i++) begin
      step();
      chk_if($sformatf("t1.%0d", i), 8'(i));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("t1.bub", 32'(bubbleCount), 32'd0);
`endif

    // stall with ready: one item into skid, IF/ID frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if($sformatf("t2.hold%0d", i), 8'd3);
      chk($sformatf("t2.req%0d", i), 32'(instrReq), 32'd0);
      chk($sformatf("t2.addr%0d", i), 32'(instrAddr), 32'h05);
    end
    stall = 1'b0;
    step();
    chk_if("t2.skid", 8'd4);
    chk("t2.req", 32'(instrReq), 32'd1);
    step();
    chk_if("t2.next", 8'd5);

    // taken branch at ifIdPc=5
    branch       = 1'b1;
    branchTarget = 8'h40;
    step();
    branch = 1'b0;
    chk("t3.flush", 32'(ifIdValid), 32'd0);
    chk("t3.addr", 32'(instrAddr), 32'h40);
    step();
    chk_if("t3.tgt", 8'h40);

    // delayed ready with branch in first wait cycle
    instrReady   = 1'b0;
    branch       = 1'b1;
    branchTarget = 8'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      branch = 1'b0;
      chk($sformatf("t4.addr%0d", i), 32'(instrAddr), 32'h41);
      chk($sformatf("t4.req%0d", i), 32'(instrReq), 32'd1);
      chk($sformatf("t4.valid%0d", i), 32'(ifIdValid), 32'd0);
    end
    instrReady = 1'b1;
    step();
    chk("t4.drop", 32'(ifIdValid), 32'd0);
    chk("t4.newaddr", 32'(instrAddr), 32'h20);
    step();
    chk_if("t4.tgt", 8'h20);

    // wrap at 8'hFF
    branch       = 1'b1;
    branchTarget = 8'hFF;
    step();
    branch = 1'b0;
    chk("t5.addr", 32'(instrAddr), 32'hFF);
    step();
    chk_if("t5.ff", 8'hFF);
    step();
    chk_if("t5.00", 8'h00);

    // async reset between edges
    #2;
    resetN = 1'b0;
    #1;
    chk("t6.req", 32'(instrReq), 32'd0);
    chk("t6.valid", 32'(ifIdValid), 32'd0);
    chk("t6.pc", 32'(ifIdPc), 32'd0);
    chk("t6.instr", 32'(ifIdInstr), 32'd0);
    chk("t6.op", 32'(opCode), 32'd0);
    chk("t6.addr", 32'(instrAddr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6.bub", 32'(bubbleCount), 32'd0);
`endif
    step();
    resetN = 1'b1;
    #1;
    chk("t6.relreq", 32'(instrReq), 32'd1);
    chk("t6.reladdr", 32'(instrAddr), 32'd0);
    step();
    chk_if("t6.first", 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
